// File: rtl/dsram_mmio_responder_pkg.sv
// Shared constants and helpers for the data-SRAM MMIO responder.
package dsram_mmio_responder_pkg;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hBFAF;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF004;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_CMP    = 16'hE004;
  localparam logic [15:0] OFF_STATUS = 16'hE008;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LED,
    REG_SWITCH,
    REG_TIMER,
    REG_CMP,
    REG_STATUS
  } mmio_reg_e;

  // Map an MMIO offset to the register it selects; unmapped offsets give REG_NONE.
  function automatic mmio_reg_e decode_reg(input logic [15:0] off);
    case (off)
      OFF_LED:    decode_reg = REG_LED;
      OFF_SWITCH: decode_reg = REG_SWITCH;
      OFF_TIMER:  decode_reg = REG_TIMER;
      OFF_CMP:    decode_reg = REG_CMP;
      OFF_STATUS: decode_reg = REG_STATUS;
      default:    decode_reg = REG_NONE;
    endcase
  endfunction

  // Replace the byte lanes of old_val whose write enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wen);
    merge_bytes = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merge_bytes[8*i +: 8] = new_val[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/dsram_mmio_responder_bram_be.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module dsram_mmio_responder_bram_be #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Byte-lane writes or a registered read; the output holds when not reading.
  // NOTE: the array and its output register have no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen == 4'b0000) begin
        rdata <= mem[addr];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dsram_mmio_responder.sv
// Data-side bus target: decodes accesses into local RAM or MMIO registers
// (LED, switches, timer with compare) and returns read data one cycle later.
module dsram_mmio_responder
  import dsram_mmio_responder_pkg::*;
#(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        timer_int
);

  logic        is_mmio;
  logic        acc_rd;
  logic        acc_wr;
  mmio_reg_e   reg_sel;
  logic        ram_en;
  logic [31:0] ram_rdata;

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [31:0] timer;
  logic [31:0] timer_cmp;
  logic        pending;
  logic        rd_from_ram;
  logic [31:0] mmio_rdata_q;

  logic [31:0] mmio_rd_val;
  logic [31:0] led_merged;
  logic [31:0] timer_merged;
  logic [31:0] cmp_merged;
  logic        cmp_hit;
  logic        status_clr;

  // Byte-offset bits are ignored for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign is_mmio = (data_sram_addr[31:16] == MMIO_HI);
  assign acc_rd  = data_sram_en && (data_sram_wen == 4'b0000);
  assign acc_wr  = data_sram_en && (data_sram_wen != 4'b0000);
  assign reg_sel = decode_reg(data_sram_addr[15:0]);
  // A reset cycle drops the access so no RAM write can slip through.
  assign ram_en  = data_sram_en && !is_mmio && !rst;

  dsram_mmio_responder_bram_be #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  // MMIO read mux plus byte-merged write values and compare/clear conditions.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mmio_rd_val = 32'h0;
    case (reg_sel)
      REG_LED:    mmio_rd_val = {16'h0, led_out};
      REG_SWITCH: mmio_rd_val = {16'h0, sw_sync};
      REG_TIMER:  mmio_rd_val = timer;
      REG_CMP:    mmio_rd_val = timer_cmp;
      REG_STATUS: mmio_rd_val = {31'h0, pending};
      default:    mmio_rd_val = 32'h0;
    endcase
    led_merged   = merge_bytes({16'h0, led_out}, data_sram_wdata, data_sram_wen);
    timer_merged = merge_bytes(timer, data_sram_wdata, data_sram_wen);
    cmp_merged   = merge_bytes(timer_cmp, data_sram_wdata, data_sram_wen);
    cmp_hit      = (timer_cmp != 32'h0) && (timer == timer_cmp);
    status_clr   = acc_wr && is_mmio && (reg_sel == REG_STATUS) &&
                   data_sram_wen[0] && data_sram_wdata[0];
  end

  // Switch synchroniser, MMIO registers, timer, pending flag and read capture.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta      <= '0;
      sw_sync      <= '0;
      led_out      <= '0;
      timer        <= '0;
      timer_cmp    <= '0;
      pending      <= 1'b0;
      rd_from_ram  <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;

      if (acc_wr && is_mmio && reg_sel == REG_TIMER) timer <= timer_merged;
      else                                            timer <= timer + 32'd1;

      if (acc_wr && is_mmio && reg_sel == REG_LED) led_out   <= led_merged[15:0];
      if (acc_wr && is_mmio && reg_sel == REG_CMP) timer_cmp <= cmp_merged;

      // A compare match in the same cycle as a clear leaves the flag set.
      if (cmp_hit)         pending <= 1'b1;
      else if (status_clr) pending <= 1'b0;

      if (acc_rd) begin
        rd_from_ram <= !is_mmio;
        if (is_mmio) mmio_rdata_q <= mmio_rd_val;
      end
    end
  end

  assign data_sram_rdata = rd_from_ram ? ram_rdata : mmio_rdata_q;
  assign timer_int       = pending;

endmodule

// File: tb/tb_dsram_mmio_responder.sv
// Directed bench for dsram_mmio_responder with a read-data scoreboard.
module tb_dsram_mmio_responder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  logic        timer_int;

  int tests  = 0;
  int failed = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  dsram_mmio_responder dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .timer_int       (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read accepted at a rising edge is compared at the next falling edge.
  initial begin
    logic fired;
    forever begin
      @(posedge clk);
      fired = en && (wen == 4'b0000) && !rst;
      @(negedge clk);
      if (fired) begin
        if (exp_q.size() == 0) begin
          check("unexpected_read", rdata, 32'hx);
        end else begin
          check(name_q.pop_front(), rdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle();
    en = 1'b0; wen = 4'b0000;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    en = 1'b1; wen = w; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; wen = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    en = 1'b1; wen = 4'b0000; addr = a; wdata = 32'h0;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'b0000; addr = 32'h0; wdata = 32'h0;
    switch_in = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    check("reset_timer_int", {31'h0, timer_int}, 32'h0);
    rst = 1'b0;

    // 1) full-word RAM write then read
    wr(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_full_word");

    // 2) single byte lane merge
    wr(32'h0000_0010, 4'b0010, 32'h0000_AA00);
    rd(32'h0000_0010, 32'hDEAD_AAEF, "ram_byte_lane");

    // 3) LED write and synchronised switch read
    switch_in = 16'h00F0;
    wr(32'hBFAF_F000, 4'hF, 32'h0000_1234);
    check("led_after_write", {16'h0, led_out}, 32'h0000_1234);
    idle();
    idle();
    rd(32'hBFAF_F004, 32'h0000_00F0, "switch_read");
    rd(32'hBFAF_F000, 32'h0000_1234, "led_read");

    // 4) timer compare, clear, set-wins, wrap
    wr(32'hBFAF_E000, 4'hF, 32'd5);
    wr(32'hBFAF_E004, 4'hF, 32'd10);
    rd(32'hBFAF_E000, 32'd6, "timer_read");
    repeat (3) idle();
    check("timer_int_before_match", {31'h0, timer_int}, 32'h0);
    idle();
    check("timer_int_on_match", {31'h0, timer_int}, 32'h1);
    rd(32'hBFAF_E008, 32'h1, "status_read");
    wr(32'hBFAF_E008, 4'hF, 32'h1);
    check("status_clear", {31'h0, timer_int}, 32'h0);
    wr(32'hBFAF_E000, 4'hF, 32'd30);
    wr(32'hBFAF_E004, 4'hF, 32'd32);
    idle();
    wr(32'hBFAF_E008, 4'hF, 32'h1);
    check("set_wins_over_clear", {31'h0, timer_int}, 32'h1);
    wr(32'hBFAF_E000, 4'hF, 32'hFFFF_FFFF);
    rd(32'hBFAF_E000, 32'hFFFF_FFFF, "timer_max");
    rd(32'hBFAF_E000, 32'h0, "timer_wrap");

    // 5) unmapped MMIO offset
    rd(32'hBFAF_F000, 32'h0000_1234, "led_before_unmapped");
    rd(32'hBFAF_0100, 32'h0, "unmapped_read");
    wr(32'hBFAF_0100, 4'hF, 32'hFFFF_FFFF);
    check("led_after_unmapped_write", {16'h0, led_out}, 32'h0000_1234);
    rd(32'hBFAF_F000, 32'h0000_1234, "led_read_after_unmapped");

    // 6) reset during a RAM write
    wr(32'h0000_0020, 4'hF, 32'h1111_1111);
    rd(32'h0000_0020, 32'h1111_1111, "ram_before_reset");
    rst = 1'b1; en = 1'b1; wen = 4'hF; addr = 32'h0000_0020; wdata = 32'h2222_2222;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; wen = 4'b0000;
    check("rdata_after_reset", rdata, 32'h0);
    check("led_after_reset", {16'h0, led_out}, 32'h0);
    check("timer_int_after_reset", {31'h0, timer_int}, 32'h0);
    rd(32'hBFAF_E000, 32'h0, "timer_after_reset");
    rd(32'h0000_0020, 32'h1111_1111, "ram_kept_over_reset");

    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
